branch_resolve_e: RTL and testbench
===================================

Name: branch_resolve_e

Overview:
- Execute-stage branch resolution unit; responder side of the fetch/gshare prediction interface.
- Captures decoded control-flow instructions in its own D->E register and evaluates the real outcome and target.
- Compares the outcome with the prediction made in fetch, then returns taken/PC/target/pattern to the predictor and drives redirect and flush into fetch and decode.
- Sits between the decode register and the fetch stage's gshare update/redirect inputs.

Parameters:
- XLEN, 32, data/address width.
- GHR_W, 10, width of the gshare pattern carried with each instruction.
- FLUSH_CYC, 2, number of cycles the flush is held after a redirect (younger instructions in F and D).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall_E  in  1  hold the D->E register (hazard stall).
- i_valid_D  in  1  decode holds a real instruction.
- i_br_en_D  in  1  conditional branch.
- i_jal_D  in  1  JAL.
- i_jalr_D  in  1  JALR.
- i_funct3_D  in  3  branch condition.
- i_pc_D  in  XLEN  instruction PC.
- i_imm_D  in  XLEN  sign-extended immediate.
- i_rs1_D  in  XLEN  forwarded rs1.
- i_rs2_D  in  XLEN  forwarded rs2.
- i_pred_taken_D  in  1  fetch prediction for this instruction.
- i_pattern_D  in  GHR_W  history snapshot from fetch.
- o_taken_E  out  1  actual outcome, to predictor.
- o_branch_E  out  1  valid conditional branch in E (predictor update enable).
- o_jump_E  out  1  valid JAL/JALR in E.
- o_pc_E  out  XLEN  PC of the resolved instruction.
- o_alu_data_E  out  XLEN  computed target.
- o_pattern_E  out  GHR_W  history echoed back for update.
- o_redirect  out  1  mispredict; fetch loads o_redirect_pc.
- o_redirect_pc  out  XLEN  correct next PC.
- o_rst_F  out  1  flush fetch register.
- o_rst_D  out  1  flush decode register.
- o_br_cnt  out  32  resolved control-flow count (optional feature).
- o_mis_cnt  out  32  mispredict count (optional feature).

Behaviour:
- Reset (async, i_rst_n=0): D->E register cleared (valid=0), FSM=IDLE, counters=0. All outputs are 0 while reset is asserted and until the first valid capture.
- D->E register:
  - Priority: flush > stall > load.
  - Loads on a clock edge when !i_stall_E.
  - Captured valid = i_valid_D & !squash, where squash = FSM in FLUSH or o_redirect this cycle.
  - When stalled, contents are held, but o_redirect can fire only once per captured instruction: a done flag is set after firing.
- Resolution is combinational from the register, so outputs are valid in the cycle after capture (latency 1).
- Conditions by funct3:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are not taken.
- taken: branch = condition result; JAL/JALR = 1.
- Target (all arithmetic modulo 2^XLEN, no overflow flag):
  - Branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
- Redirect decision:
  - Branch: mispredict = taken XOR pred_taken.
  - JAL: mispredict = !pred_taken.
  - JALR: always redirect.
  - o_redirect_pc = taken ? target : pc+4.
  - o_redirect asserts only when valid & !done.
- FSM:
  - IDLE: goes to FLUSH when o_redirect; loads a count of FLUSH_CYC-1.
  - FLUSH: decrements the count; returns to IDLE at 0.
  - o_rst_F = o_rst_D = o_redirect | (state==FLUSH).
  - A redirect from a squashed instruction is impossible because it is captured as invalid.
- Invalid entry: o_taken_E, o_branch_E, o_jump_E and o_redirect are 0. o_pc_E, o_alu_data_E and o_pattern_E still reflect the register contents, and the predictor must ignore them.
- Reset mid-flush: FSM returns to IDLE immediately and flush outputs deassert asynchronously.

Optional Feature:
- Macro: BR_PERF_CNT_EN.
- Defined:
  - o_br_cnt increments on each valid resolution (branch or jump, counted once per instruction, not per stall cycle).
  - o_mis_cnt increments on each o_redirect.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Reset release, then BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=1 -> next cycle o_taken_E=1, o_alu_data_E=0x120, o_redirect=0, no flush.
- BNE pc=0x200, imm=-8, rs1=rs2=3, pred_taken=1 -> o_taken_E=0, o_redirect=1, o_redirect_pc=0x204, o_rst_F/o_rst_D high for 2 cycles. An instruction presented during the flush is captured invalid.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. funct3=010 -> not taken.
- JALR rs1=0x1001, imm=4 -> o_redirect_pc=0x1004 (bit0 cleared), redirect asserted even with pred_taken=1.
- Mispredicting branch held by i_stall_E for 3 cycles -> o_redirect pulses exactly once. Asserting i_rst_n=0 during FLUSH -> all outputs 0 asynchronously.
- With BR_PERF_CNT_EN defined, run 5 branches with 2 mispredicts -> o_br_cnt=5, o_mis_cnt=2. Without it, both read 0.

Source files
------------

// File: rtl/branch_resolve_e_if.sv
// branch_resolve_e_if: decode-side capture inputs and execute-side
// resolution outputs of the branch resolution unit.
//   master : decode/fetch side. Drives the instruction fields and the stall,
//            and consumes the resolution, redirect and flush outputs.
//   slave  : branch_resolve_e.
// Signal names match the unit's port names.
interface branch_resolve_e_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 10
);
  logic             i_stall_E;
  logic             i_valid_D;
  logic             i_br_en_D;
  logic             i_jal_D;
  logic             i_jalr_D;
  logic [2:0]       i_funct3_D;
  logic [XLEN-1:0]  i_pc_D;
  logic [XLEN-1:0]  i_imm_D;
  logic [XLEN-1:0]  i_rs1_D;
  logic [XLEN-1:0]  i_rs2_D;
  logic             i_pred_taken_D;
  logic [GHR_W-1:0] i_pattern_D;

  logic             o_taken_E;
  logic             o_branch_E;
  logic             o_jump_E;
  logic [XLEN-1:0]  o_pc_E;
  logic [XLEN-1:0]  o_alu_data_E;
  logic [GHR_W-1:0] o_pattern_E;
  logic             o_redirect;
  logic [XLEN-1:0]  o_redirect_pc;
  logic             o_rst_F;
  logic             o_rst_D;
  logic [31:0]      o_br_cnt;
  logic [31:0]      o_mis_cnt;

  modport master (
    output i_stall_E, i_valid_D, i_br_en_D, i_jal_D, i_jalr_D, i_funct3_D,
           i_pc_D, i_imm_D, i_rs1_D, i_rs2_D, i_pred_taken_D, i_pattern_D,
    input  o_taken_E, o_branch_E, o_jump_E, o_pc_E, o_alu_data_E, o_pattern_E,
           o_redirect, o_redirect_pc, o_rst_F, o_rst_D, o_br_cnt, o_mis_cnt
  );

  modport slave (
    input  i_stall_E, i_valid_D, i_br_en_D, i_jal_D, i_jalr_D, i_funct3_D,
           i_pc_D, i_imm_D, i_rs1_D, i_rs2_D, i_pred_taken_D, i_pattern_D,
    output o_taken_E, o_branch_E, o_jump_E, o_pc_E, o_alu_data_E, o_pattern_E,
           o_redirect, o_redirect_pc, o_rst_F, o_rst_D, o_br_cnt, o_mis_cnt
  );
endinterface

// File: rtl/branch_resolve_e.sv
// branch_resolve_e: execute-stage branch resolution unit.
// Captures a decoded control-flow instruction in its D->E register, resolves
// outcome and target combinationally (latency 1), returns taken/pc/target/
// pattern to the gshare predictor and drives redirect plus F/D flush.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      branch_resolve_e_if.slave (decode inputs, resolution outputs)
// Optional feature: define BR_PERF_CNT_EN for saturating resolved/mispredict
// counters on o_br_cnt/o_mis_cnt; otherwise both read 0 and have no flops.
module branch_resolve_e #(
  parameter int XLEN      = 32,
  parameter int GHR_W     = 10,
  parameter int FLUSH_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  branch_resolve_e_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam int CNT_W = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

  // D->E register
  logic             v_q, done_q, br_q, jal_q, jalr_q, pred_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  pc_q, imm_q, rs1_q, rs2_q;
  logic [GHR_W-1:0] pat_q;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic            cond, taken, mis, redirect, squash;
  logic [XLEN-1:0] target;

  always_comb begin
    cond = 1'b0;
    case (f3_q)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase

    target = jalr_q ? ((rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0})
                    : (pc_q + imm_q);

    taken = v_q & (jal_q | jalr_q | (br_q & cond));

    // JALR target is unknown to fetch, so it always redirects.
    mis = 1'b0;
    if (jalr_q)     mis = 1'b1;
    else if (jal_q) mis = ~pred_q;
    else if (br_q)  mis = cond ^ pred_q;

    redirect = v_q & ~done_q & mis;
    squash   = redirect | (state_q == FLUSH);
  end

  // Flush FSM: the redirect cycle itself flushes, FLUSH covers the rest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (redirect && (FLUSH_CYC > 1)) begin
          state_n = FLUSH;
          cnt_n   = CNT_LOAD;
        end
      end
      FLUSH: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A stalled entry is held even across its own redirect; done_q marks it
  // as already resolved so redirect and counting happen once per entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q    <= 1'b0;
      done_q <= 1'b0;
      br_q   <= 1'b0;
      jal_q  <= 1'b0;
      jalr_q <= 1'b0;
      pred_q <= 1'b0;
      f3_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pat_q  <= '0;
    end else if (!bus.i_stall_E) begin
      v_q    <= bus.i_valid_D & ~squash;
      done_q <= 1'b0;
      br_q   <= bus.i_br_en_D;
      jal_q  <= bus.i_jal_D;
      jalr_q <= bus.i_jalr_D;
      pred_q <= bus.i_pred_taken_D;
      f3_q   <= bus.i_funct3_D;
      pc_q   <= bus.i_pc_D;
      imm_q  <= bus.i_imm_D;
      rs1_q  <= bus.i_rs1_D;
      rs2_q  <= bus.i_rs2_D;
      pat_q  <= bus.i_pattern_D;
    end else begin
      done_q <= done_q | v_q;
    end
  end

  assign bus.o_taken_E     = taken;
  assign bus.o_branch_E    = v_q & br_q & ~jal_q & ~jalr_q;
  assign bus.o_jump_E      = v_q & (jal_q | jalr_q);
  assign bus.o_pc_E        = pc_q;
  assign bus.o_alu_data_E  = target;
  assign bus.o_pattern_E   = pat_q;
  assign bus.o_redirect    = redirect;
  assign bus.o_redirect_pc = !v_q ? '0 : (taken ? target : pc_q + XLEN'(4));
  assign bus.o_rst_F       = squash;
  assign bus.o_rst_D       = squash;

`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt_q, mis_cnt_q;
  logic        first;

  assign first = v_q & ~done_q & (br_q | jal_q | jalr_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (first && (br_cnt_q != '1))     br_cnt_q  <= br_cnt_q + 32'd1;
      if (redirect && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign bus.o_br_cnt  = br_cnt_q;
  assign bus.o_mis_cnt = mis_cnt_q;
`else
  assign bus.o_br_cnt  = '0;
  assign bus.o_mis_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_e.sv
module tb_branch_resolve_e;
  localparam int XLEN  = 32;
  localparam int GHR_W = 10;
  localparam int FLUSH_CYC = 2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  branch_resolve_e_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bus ();

  branch_resolve_e #(.XLEN(XLEN), .GHR_W(GHR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        v, br, jal, jalr, pred;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2;
    logic [9:0]  pat;
  } ent_t;

  ent_t        m;
  logic        m_done;
  int          flush_left;
  int unsigned m_br, m_mis;

  function automatic logic cond_of(ent_t e);
    case (e.f3)
      3'd0: return e.rs1 == e.rs2;
      3'd1: return e.rs1 != e.rs2;
      3'd4: return $signed(e.rs1) <  $signed(e.rs2);
      3'd5: return $signed(e.rs1) >= $signed(e.rs2);
      3'd6: return e.rs1 <  e.rs2;
      3'd7: return e.rs1 >= e.rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] tgt_of(ent_t e);
    logic [31:0] s;
    if (e.jalr) begin
      s = e.rs1 + e.imm;
      return {s[31:1], 1'b0};
    end
    return e.pc + e.imm;
  endfunction

  function automatic logic taken_of(ent_t e);
    if (!e.v) return 1'b0;
    if (e.jal || e.jalr) return 1'b1;
    return e.br && cond_of(e);
  endfunction

  // Fetch predicted next pc = pred ? target : pc+4 (JALR target unknown there).
  function automatic logic red_of(ent_t e, logic done);
    logic ctl;
    ctl = e.br | e.jal | e.jalr;
    if (!e.v || done || !ctl) return 1'b0;
    return e.jalr || (taken_of(e) != e.pred);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin : model
    ent_t n;
    logic red;
    if (!i_rst_n) begin
      m <= '{default: '0};
      m_done <= 1'b0;
      flush_left <= 0;
      m_br <= 0;
      m_mis <= 0;
    end else begin
      red = red_of(m, m_done);
      if (flush_left > 0) flush_left <= flush_left - 1;
      else if (red)       flush_left <= FLUSH_CYC - 1;
      if (m.v && !m_done && (m.br || m.jal || m.jalr)) m_br <= m_br + 1;
      if (red) m_mis <= m_mis + 1;
      if (!bus.i_stall_E) begin
        n.v = bus.i_valid_D && !(red || flush_left > 0);
        n.br = bus.i_br_en_D; n.jal = bus.i_jal_D; n.jalr = bus.i_jalr_D;
        n.pred = bus.i_pred_taken_D; n.f3 = bus.i_funct3_D;
        n.pc = bus.i_pc_D; n.imm = bus.i_imm_D;
        n.rs1 = bus.i_rs1_D; n.rs2 = bus.i_rs2_D; n.pat = bus.i_pattern_D;
        m <= n;
        m_done <= 1'b0;
      end else begin
        m_done <= m_done | m.v;
      end
    end
  end

  // Compare process: every negedge, DUT against model.
  always @(negedge i_clk) begin : cmp
    logic red, tk, ctl;
    if (!i_rst_n) begin
      chk("rst_taken", {31'd0, bus.o_taken_E}, 32'd0);
      chk("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
      chk("rst_flush", {30'd0, bus.o_rst_F, bus.o_rst_D}, 32'd0);
      chk("rst_pc", bus.o_pc_E, 32'd0);
      chk("rst_rpc", bus.o_redirect_pc, 32'd0);
    end else begin
      red = red_of(m, m_done);
      tk  = taken_of(m);
      ctl = m.jal | m.jalr;
      chk("taken", {31'd0, bus.o_taken_E}, {31'd0, tk});
      chk("branch", {31'd0, bus.o_branch_E}, {31'd0, m.v & m.br & ~ctl});
      chk("jump", {31'd0, bus.o_jump_E}, {31'd0, m.v & ctl});
      chk("pc", bus.o_pc_E, m.pc);
      chk("alu", bus.o_alu_data_E, tgt_of(m));
      chk("pattern", {22'd0, bus.o_pattern_E}, {22'd0, m.pat});
      chk("redirect", {31'd0, bus.o_redirect}, {31'd0, red});
      chk("redirect_pc", bus.o_redirect_pc, !m.v ? 32'd0 : (tk ? tgt_of(m) : m.pc + 32'd4));
      chk("rst_F", {31'd0, bus.o_rst_F}, {31'd0, red | (flush_left > 0)});
      chk("rst_D", {31'd0, bus.o_rst_D}, {31'd0, red | (flush_left > 0)});
`ifdef BR_PERF_CNT_EN
      chk("br_cnt", bus.o_br_cnt, m_br);
      chk("mis_cnt", bus.o_mis_cnt, m_mis);
`else
      chk("br_cnt", bus.o_br_cnt, 32'd0);
      chk("mis_cnt", bus.o_mis_cnt, 32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input logic v, input logic br, input logic jal, input logic jalr,
                     input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
    bus.i_valid_D = v;   bus.i_br_en_D = br; bus.i_jal_D = jal; bus.i_jalr_D = jalr;
    bus.i_funct3_D = f3; bus.i_pc_D = pc;    bus.i_imm_D = imm;
    bus.i_rs1_D = rs1;   bus.i_rs2_D = rs2;  bus.i_pred_taken_D = pred;
    bus.i_pattern_D = pc[11:2];
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic brn(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
    put(1, 1, 0, 0, f3, pc, imm, rs1, rs2, pred);
  endtask

  initial begin
    int pulses;
    bus.i_stall_E = 1'b0;
    idle();
    tick(); tick();
    chk("lit_reset_redirect", {31'd0, bus.o_redirect}, 32'd0);
    chk("lit_reset_pc", bus.o_pc_E, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // BEQ taken, predicted taken
    brn(3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1); tick();
    chk("lit_beq_taken", {31'd0, bus.o_taken_E}, 32'd1);
    chk("lit_beq_alu", bus.o_alu_data_E, 32'h120);
    chk("lit_beq_redirect", {31'd0, bus.o_redirect}, 32'd0);
    chk("lit_beq_flush", {31'd0, bus.o_rst_F}, 32'd0);

    // BNE not taken, predicted taken -> redirect to pc+4 and 2-cycle flush
    brn(3'd1, 32'h200, 32'hFFFF_FFF8, 32'd3, 32'd3, 1); tick();
    chk("lit_bne_taken", {31'd0, bus.o_taken_E}, 32'd0);
    chk("lit_bne_redirect", {31'd0, bus.o_redirect}, 32'd1);
    chk("lit_bne_rpc", bus.o_redirect_pc, 32'h204);
    chk("lit_bne_flush1", {30'd0, bus.o_rst_F, bus.o_rst_D}, 32'd3);
    brn(3'd0, 32'h204, 32'h10, 32'd1, 32'd1, 0); tick();
    chk("lit_flush2", {30'd0, bus.o_rst_F, bus.o_rst_D}, 32'd3);
    chk("lit_squashed_branch", {31'd0, bus.o_branch_E}, 32'd0);
    brn(3'd0, 32'h208, 32'h10, 32'd1, 32'd1, 0); tick();
    chk("lit_flush_end", {31'd0, bus.o_rst_F}, 32'd0);
    chk("lit_squashed_branch2", {31'd0, bus.o_branch_E}, 32'd0);

    // Signed vs unsigned compare, reserved funct3
    brn(3'd4, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1, 1); tick();
    chk("lit_blt_taken", {31'd0, bus.o_taken_E}, 32'd1);
    brn(3'd6, 32'h310, 32'h10, 32'hFFFF_FFFF, 32'd1, 0); tick();
    chk("lit_bltu_taken", {31'd0, bus.o_taken_E}, 32'd0);
    brn(3'd2, 32'h320, 32'h10, 32'd7, 32'd7, 0); tick();
    chk("lit_f3_010_taken", {31'd0, bus.o_taken_E}, 32'd0);

    // JALR clears bit0 and always redirects
    put(1, 0, 0, 1, 3'd0, 32'h400, 32'd4, 32'h1001, 32'd0, 1); tick();
    chk("lit_jalr_redirect", {31'd0, bus.o_redirect}, 32'd1);
    chk("lit_jalr_rpc", bus.o_redirect_pc, 32'h1004);
    chk("lit_jalr_jump", {31'd0, bus.o_jump_E}, 32'd1);
    idle(); tick(); tick();

    // JAL predicted not taken -> redirect to pc+imm
    put(1, 0, 1, 0, 3'd0, 32'h480, 32'h40, 32'd0, 32'd0, 0); tick();
    chk("lit_jal_rpc", bus.o_redirect_pc, 32'h4C0);
    idle(); tick(); tick();

    // Mispredicting branch held by stall for 3 cycles: one redirect pulse
    brn(3'd0, 32'h500, 32'h40, 32'd1, 32'd2, 1); tick();
    pulses = int'(bus.o_redirect);
    chk("lit_stall_rpc", bus.o_redirect_pc, 32'h504);
    idle();
    bus.i_stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(bus.o_redirect);
    end
    chk("lit_stall_pulses", pulses, 32'd1);
    bus.i_stall_E = 1'b0;
    tick(); tick();

    // Reset asserted during FLUSH clears all outputs asynchronously
    brn(3'd1, 32'h600, 32'h8, 32'd4, 32'd4, 1); tick();
    idle();
    @(posedge i_clk); #1;
    chk("lit_in_flush", {31'd0, bus.o_rst_F}, 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("lit_async_flush", {30'd0, bus.o_rst_F, bus.o_rst_D}, 32'd0);
    chk("lit_async_pc", bus.o_pc_E, 32'd0);
    chk("lit_async_pattern", {22'd0, bus.o_pattern_E}, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // 5 branches, 2 mispredicts
    brn(3'd0, 32'h700, 32'h10, 32'd1, 32'd1, 1); tick(); idle(); tick(); tick();
    brn(3'd1, 32'h710, 32'h10, 32'd1, 32'd1, 1); tick(); idle(); tick(); tick();
    brn(3'd4, 32'h720, 32'h10, 32'hFFFF_FFF0, 32'd1, 1); tick(); idle(); tick(); tick();
    brn(3'd7, 32'h730, 32'h10, 32'd1, 32'd2, 1); tick(); idle(); tick(); tick();
    brn(3'd0, 32'h740, 32'h10, 32'd1, 32'd2, 0); tick(); idle(); tick(); tick();
`ifdef BR_PERF_CNT_EN
    chk("lit_br_cnt", bus.o_br_cnt, 32'd5);
    chk("lit_mis_cnt", bus.o_mis_cnt, 32'd2);
`else
    chk("lit_br_cnt", bus.o_br_cnt, 32'd0);
    chk("lit_mis_cnt", bus.o_mis_cnt, 32'd0);
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
